// File: rtl/flood_pkg.sv
// -----------------------------------------------------------------------------
// flood_pkg
// Shared definitions for the Flood-It blocks: board geometry limits, field
// widths, default random seed, the board generator state encoding and a
// colour-count clamp helper.
// -----------------------------------------------------------------------------
package flood_pkg;

    localparam int              LFSR_W       = 16;
    localparam logic [15:0]     DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0]     LFSR_TAPS    = 16'hB400;
    localparam int              MAX_SIZE     = 26;
    localparam int              COLOR_W      = 3;
    localparam int              COORD_W      = 5;
    localparam int              CNUM_W       = 4;

    // Board generator states. IDLE must stay the only non-busy state.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_WAIT_IDLE,
        ST_HANDOFF,
        ST_RELEASE
    } gen_state_t;

    // Colour counts outside 2..8 are pulled to the nearest legal value.
    function automatic logic [CNUM_W-1:0] clamp_colors(input logic [CNUM_W-1:0] n);
        if (n < 4'd2) begin
            return 4'd2;
        end
        if (n > 4'd8) begin
            return 4'd8;
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Galois LFSR, right-shifting, reusable for any random feature.
// Ports:
//   CLOCK   in  clock, rising edge
//   RESET_N in  asynchronous active-low reset, Q returns to DFLT
//   EN      in  advance one step this cycle
//   LOAD    in  load SEED (DFLT when SEED is zero); wins over EN
//   SEED    in  seed value
//   Q       out current register value
// -----------------------------------------------------------------------------
module lfsr16
    import flood_pkg::*;
#(
    parameter int         W    = 16,
    parameter logic [W-1:0] TAPS = LFSR_TAPS,
    parameter logic [W-1:0] DFLT = DEFAULT_SEED
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic         EN,
    input  logic         LOAD,
    input  logic [W-1:0] SEED,
    output logic [W-1:0] Q
);

    // An all-zero state would lock the register, so a zero seed is replaced.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            Q <= DFLT;
        end else if (LOAD) begin
            Q <= (SEED == '0) ? DFLT : SEED;
        end else if (EN) begin
            Q <= {1'b0, Q[W-1:1]} ^ (Q[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/board_generator.sv
// -----------------------------------------------------------------------------
// board_generator
// Fills the initial-board store with a random SIZE x SIZE Flood-It board, one
// cell per accepted draw in row-major order, then runs the start handshake
// with the game logic.
//
// Handshake (BEGIN_GAME / STARTED_GAME): BEGIN_GAME is raised only when the
// game logic is not flooding (CHANGING_COLOR low) and is held until
// STARTED_GAME is sampled high; it then drops on the next edge and the block
// waits for STARTED_GAME to return low before pulsing DONE and going idle.
//
// Ports:
//   CLOCK, RESET_N            clock / async active-low reset
//   NEW_GAME                  one-cycle request (honoured in IDLE only)
//   SEED, SEED_LOAD           LFSR seed load, any state
//   SIZE, COLOR_NUM           board edge (2..26) and colour count (clamped 2..8)
//   CELL_WE/ROW/COL/COLOR     write port into the initial-board store
//   BEGIN_GAME, STARTED_GAME  start request / acknowledge
//   CHANGING_COLOR            game logic busy flooding
//   BUSY                      not idle
//   DONE                      one-cycle pulse when the handshake completes
//   BAD_CFG                   sticky: last NEW_GAME had an illegal SIZE
// -----------------------------------------------------------------------------
module board_generator
    import flood_pkg::*;
#(
    parameter int                LFSR_W       = flood_pkg::LFSR_W,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = flood_pkg::DEFAULT_SEED,
    parameter int                MAX_SIZE     = flood_pkg::MAX_SIZE
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               NEW_GAME,
    input  logic [LFSR_W-1:0]  SEED,
    input  logic               SEED_LOAD,
    input  logic [COORD_W-1:0] SIZE,
    input  logic [CNUM_W-1:0]  COLOR_NUM,
    output logic               CELL_WE,
    output logic [COORD_W-1:0] CELL_ROW,
    output logic [COORD_W-1:0] CELL_COL,
    output logic [COLOR_W-1:0] CELL_COLOR,
    output logic               BEGIN_GAME,
    input  logic               STARTED_GAME,
    input  logic               CHANGING_COLOR,
    output logic               BUSY,
    output logic               DONE,
    output logic               BAD_CFG
);

    gen_state_t         state_q, state_d;
    logic [COORD_W-1:0] sz_q, sz_d;
    logic [CNUM_W-1:0]  cn_q, cn_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic [COORD_W-1:0] cell_row_q, cell_row_d, cell_col_q, cell_col_d;
    logic [COLOR_W-1:0] cell_color_q, cell_color_d;
    logic               we_q, we_d;
    logic               begin_q, begin_d;
    logic               done_q, done_d;
    logic               bad_q, bad_d;

    logic [LFSR_W-1:0]  lfsr_q;
    logic               lfsr_unused;
    logic               size_ok;
    logic               accept;
    logic               last_col;
    logic               last_row;

    lfsr16 #(
        .W    (LFSR_W),
        .DFLT (DEFAULT_SEED)
    ) u_lfsr (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .EN      (state_q == ST_DRAW),
        .LOAD    (SEED_LOAD),
        .SEED    (SEED),
        .Q       (lfsr_q)
    );

    // Only the low colour bits pick a colour; the rest just feeds the sequence.
    assign lfsr_unused = ^lfsr_q[LFSR_W-1:COLOR_W];

    assign size_ok  = (SIZE >= COORD_W'(2)) && (SIZE <= COORD_W'(MAX_SIZE));
    // Rejection sampling keeps the colour distribution uniform over 0..cn_q-1.
    assign accept   = ({1'b0, lfsr_q[COLOR_W-1:0]} < cn_q);
    assign last_col = (col_q == sz_q - COORD_W'(1));
    assign last_row = (row_q == sz_q - COORD_W'(1));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            sz_q         <= '0;
            cn_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cell_row_q   <= '0;
            cell_col_q   <= '0;
            cell_color_q <= '0;
            we_q         <= 1'b0;
            begin_q      <= 1'b0;
            done_q       <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sz_q         <= sz_d;
            cn_q         <= cn_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cell_row_q   <= cell_row_d;
            cell_col_q   <= cell_col_d;
            cell_color_q <= cell_color_d;
            we_q         <= we_d;
            begin_q      <= begin_d;
            done_q       <= done_d;
            bad_q        <= bad_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sz_d         = sz_q;
        cn_d         = cn_q;
        row_d        = row_q;
        col_d        = col_q;
        cell_row_d   = cell_row_q;
        cell_col_d   = cell_col_q;
        cell_color_d = cell_color_q;
        we_d         = 1'b0;
        begin_d      = begin_q;
        done_d       = 1'b0;
        bad_d        = bad_q;

        case (state_q)
            ST_IDLE: begin
                begin_d = 1'b0;
                if (NEW_GAME) begin
                    sz_d = SIZE;
                    cn_d = clamp_colors(COLOR_NUM);
                    if (size_ok) begin
                        bad_d   = 1'b0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ST_DRAW;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end

            ST_DRAW: begin
                if (accept) begin
                    we_d         = 1'b1;
                    cell_row_d   = row_q;
                    cell_col_d   = col_q;
                    cell_color_d = lfsr_q[COLOR_W-1:0];
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = ST_WAIT_IDLE;
                        end else begin
                            row_d = row_q + COORD_W'(1);
                        end
                    end else begin
                        col_d = col_q + COORD_W'(1);
                    end
                end
            end

            // Game logic ignores a start request while it is flooding.
            ST_WAIT_IDLE: begin
                if (!CHANGING_COLOR) begin
                    begin_d = 1'b1;
                    state_d = ST_HANDOFF;
                end
            end

            ST_HANDOFF: begin
                if (STARTED_GAME) begin
                    begin_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                begin_d = 1'b0;
                if (!STARTED_GAME) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                begin_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign CELL_WE    = we_q;
    assign CELL_ROW   = cell_row_q;
    assign CELL_COL   = cell_col_q;
    assign CELL_COLOR = cell_color_q;
    assign BEGIN_GAME = begin_q;
    assign DONE       = done_q;
    assign BAD_CFG    = bad_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_board_generator.sv
// -----------------------------------------------------------------------------
// tb_board_generator
// Self-checking bench for board_generator. The reference model tracks the
// random sequence as plain arithmetic (halve, xor the taps when the dropped
// bit was one), derives each expected cell from its write index, and plays
// the game-logic responder for the start handshake.
// -----------------------------------------------------------------------------
module tb_board_generator;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        NEW_GAME = 1'b0;
  logic [15:0] SEED = 16'h0;
  logic        SEED_LOAD = 1'b0;
  logic [4:0]  SIZE = 5'd0;
  logic [3:0]  COLOR_NUM = 4'd0;
  logic        STARTED_GAME = 1'b0;
  logic        CHANGING_COLOR = 1'b0;
  logic        CELL_WE;
  logic [4:0]  CELL_ROW;
  logic [4:0]  CELL_COL;
  logic [2:0]  CELL_COLOR;
  logic        BEGIN_GAME;
  logic        BUSY;
  logic        DONE;
  logic        BAD_CFG;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_lfsr = 16'hACE1;

  board_generator dut (
    .CLOCK          (CLOCK),
    .RESET_N        (RESET_N),
    .NEW_GAME       (NEW_GAME),
    .SEED           (SEED),
    .SEED_LOAD      (SEED_LOAD),
    .SIZE           (SIZE),
    .COLOR_NUM      (COLOR_NUM),
    .CELL_WE        (CELL_WE),
    .CELL_ROW       (CELL_ROW),
    .CELL_COL       (CELL_COL),
    .CELL_COLOR     (CELL_COLOR),
    .BEGIN_GAME     (BEGIN_GAME),
    .STARTED_GAME   (STARTED_GAME),
    .CHANGING_COLOR (CHANGING_COLOR),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .BAD_CFG        (BAD_CFG)
  );

  // ---------------- clock / reset ----------------
  always #5 CLOCK = ~CLOCK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic [15:0] n;
    n = v / 16'd2;
    if (v % 16'd2 == 16'd1) n = n ^ 16'hB400;
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic load_seed(input logic [15:0] s);
    SEED = s;
    SEED_LOAD = 1'b1;
    tick();
    SEED_LOAD = 1'b0;
    model_lfsr = (s == 16'h0) ? 16'hACE1 : s;
  endtask

  // Requests a board and follows it draw by draw. Stops after stop_at writes
  // (0 = whole board). Leaves the bench just after the last write it saw.
  task automatic gen_board(input int size, input int cn, input int stop_at, output int n_written);
    int          cn_eff;
    int          target;
    int          cyc;
    int          exp_r;
    int          exp_c;
    logic [15:0] v;
    logic        acc;
    bit          seen [0:25][0:25];
    foreach (seen[r, c]) seen[r][c] = 1'b0;
    cn_eff = (cn < 2) ? 2 : ((cn > 8) ? 8 : cn);
    target = (stop_at != 0) ? stop_at : size * size;
    n_written = 0;
    cyc = 0;
    SIZE = 5'(size);
    COLOR_NUM = 4'(cn);
    NEW_GAME = 1'b1;
    tick();
    NEW_GAME = 1'b0;
    if (BUSY !== 1'b1 || BAD_CFG !== 1'b0) begin
      failures++;
      $display("FAIL gen_start: BUSY=%b BAD_CFG=%b, required BUSY=1 BAD_CFG=0", BUSY, BAD_CFG);
    end
    checks++;
    while (n_written < target && cyc < 20000) begin
      v = model_lfsr;
      model_lfsr = model_step(v);
      tick();
      cyc++;
      acc = (int'(v % 16'd8) < cn_eff);
      if (CELL_WE !== acc) begin
        failures++;
        $display("FAIL cell_we: cycle %0d got %b, required %b (draw value %h)", cyc, CELL_WE, acc, v);
      end
      checks++;
      if (acc) begin
        exp_r = n_written / size;
        exp_c = n_written % size;
        if ({CELL_ROW, CELL_COL, CELL_COLOR} !== {5'(exp_r), 5'(exp_c), 3'(v % 16'd8)}) begin
          failures++;
          $display("FAIL cell_data: write %0d got (%0d,%0d) colour %0d, required (%0d,%0d) colour %0d",
                   n_written, CELL_ROW, CELL_COL, CELL_COLOR, exp_r, exp_c, v % 16'd8);
        end
        checks++;
        if (int'(CELL_COLOR) >= cn_eff) begin
          failures++;
          $display("FAIL colour_range: got %0d, required < %0d", CELL_COLOR, cn_eff);
        end
        checks++;
        if (CELL_ROW < 5'd26 && CELL_COL < 5'd26) begin
          if (seen[CELL_ROW][CELL_COL]) begin
            failures++;
            $display("FAIL duplicate_cell: (%0d,%0d) written twice, required once", CELL_ROW, CELL_COL);
          end
          checks++;
          seen[CELL_ROW][CELL_COL] = 1'b1;
        end
        n_written++;
      end
    end
    if (n_written != target) begin
      failures++;
      $display("FAIL gen_budget: got %0d writes in %0d cycles, required %0d", n_written, cyc, target);
    end
    checks++;
    if (BEGIN_GAME !== 1'b0) begin
      failures++;
      $display("FAIL begin_during_gen: got %b, required 0", BEGIN_GAME);
    end
    checks++;
  endtask

  // Game-logic responder: called right after BEGIN_GAME was seen high.
  task automatic do_handshake(input int ack_dly, input int drop_dly);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      if (BEGIN_GAME !== 1'b1 || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL begin_hold: BEGIN_GAME=%b BUSY=%b, required 1 1", BEGIN_GAME, BUSY);
      end
      checks++;
    end
    STARTED_GAME = 1'b1;
    tick();
    if (BEGIN_GAME !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL begin_fall: BEGIN_GAME=%b DONE=%b BUSY=%b, required 0 0 1", BEGIN_GAME, DONE, BUSY);
    end
    checks++;
    for (int i = 0; i < drop_dly; i++) begin
      tick();
      if (BEGIN_GAME !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL release_wait: BEGIN_GAME=%b DONE=%b BUSY=%b, required 0 0 1", BEGIN_GAME, DONE, BUSY);
      end
      checks++;
    end
    STARTED_GAME = 1'b0;
    tick();
    if (DONE !== 1'b1 || BUSY !== 1'b0 || BEGIN_GAME !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: DONE=%b BUSY=%b BEGIN_GAME=%b, required 1 0 0", DONE, BUSY, BEGIN_GAME);
    end
    checks++;
    tick();
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL done_single: DONE=%b BUSY=%b, required 0 0", DONE, BUSY);
    end
    checks++;
  endtask

  // After the last write, one more edge must raise BEGIN_GAME (CHANGING_COLOR low).
  task automatic expect_begin_next();
    tick();
    if (CELL_WE !== 1'b0 || BEGIN_GAME !== 1'b1) begin
      failures++;
      $display("FAIL begin_rise: CELL_WE=%b BEGIN_GAME=%b, required 0 1", CELL_WE, BEGIN_GAME);
    end
    checks++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET_N = 1'b0;
    #12;
    if ({CELL_WE, CELL_ROW, CELL_COL, CELL_COLOR, BEGIN_GAME, BUSY, DONE, BAD_CFG} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {CELL_WE, CELL_ROW, CELL_COL, CELL_COLOR, BEGIN_GAME, BUSY, DONE, BAD_CFG});
    end
    checks++;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    tick();
    model_lfsr = 16'hACE1;
  endtask

  task automatic test_small_board();
    int n;
    load_seed(16'h0001);
    CHANGING_COLOR = 1'b0;
    gen_board(2, 8, 0, n);
    if (n != 4) begin
      failures++;
      $display("FAIL small_count: got %0d writes, required 4", n);
    end
    checks++;
    expect_begin_next();
  endtask

  task automatic test_handshake();
    do_handshake(3, 2);
  endtask

  task automatic test_large_board();
    int n;
    load_seed(16'($urandom_range(1, 65535)));
    gen_board(26, 3, 0, n);
    if (n != 676) begin
      failures++;
      $display("FAIL large_count: got %0d writes, required 676", n);
    end
    checks++;
    expect_begin_next();
    do_handshake($urandom_range(1, 5), $urandom_range(0, 4));
  endtask

  task automatic test_changing_color();
    int n;
    load_seed(16'($urandom_range(1, 65535)));
    CHANGING_COLOR = 1'b1;
    gen_board(5, $urandom_range(2, 8), 0, n);
    for (int i = 0; i < 10; i++) begin
      // A NEW_GAME while busy, even an illegal one, must change nothing.
      if (i == 4) begin
        SIZE = 5'd27;
        NEW_GAME = 1'b1;
      end
      tick();
      NEW_GAME = 1'b0;
      if (BEGIN_GAME !== 1'b0 || BUSY !== 1'b1 || CELL_WE !== 1'b0 || BAD_CFG !== 1'b0) begin
        failures++;
        $display("FAIL wait_flood: BEGIN_GAME=%b BUSY=%b CELL_WE=%b BAD_CFG=%b, required 0 1 0 0",
                 BEGIN_GAME, BUSY, CELL_WE, BAD_CFG);
      end
      checks++;
    end
    CHANGING_COLOR = 1'b0;
    expect_begin_next();
    do_handshake(1, 0);
  endtask

  task automatic test_bad_cfg();
    int n;
    logic [4:0] bad_sizes [0:3];
    bad_sizes[0] = 5'd27;
    bad_sizes[1] = 5'd1;
    bad_sizes[2] = 5'd0;
    bad_sizes[3] = 5'($urandom_range(28, 31));
    for (int k = 0; k < 4; k++) begin
      SIZE = bad_sizes[k];
      COLOR_NUM = 4'd4;
      NEW_GAME = 1'b1;
      tick();
      NEW_GAME = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (BAD_CFG !== 1'b1 || BUSY !== 1'b0 || CELL_WE !== 1'b0) begin
          failures++;
          $display("FAIL bad_cfg size %0d: BAD_CFG=%b BUSY=%b CELL_WE=%b, required 1 0 0",
                   bad_sizes[k], BAD_CFG, BUSY, CELL_WE);
        end
        checks++;
        tick();
      end
    end
    // Illegal requests must not have advanced the sequence; gen_board also
    // requires BAD_CFG to clear.
    gen_board(3, $urandom_range(0, 15), 0, n);
    expect_begin_next();
    do_handshake(2, 1);
  endtask

  task automatic test_reset_mid();
    int n;
    int cn;
    cn = $urandom_range(2, 8);
    load_seed(16'($urandom_range(1, 65535)));
    gen_board(10, cn, 50, n);
    RESET_N = 1'b0;
    #1;
    if (CELL_WE !== 1'b0 || BEGIN_GAME !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: CELL_WE=%b BEGIN_GAME=%b BUSY=%b, required 0 0 0", CELL_WE, BEGIN_GAME, BUSY);
    end
    checks++;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    tick();
    // Sequence restarts from the default seed; first write must be (0,0).
    model_lfsr = 16'hACE1;
    gen_board(10, cn, 0, n);
    if (n != 100) begin
      failures++;
      $display("FAIL restart_count: got %0d writes, required 100", n);
    end
    checks++;
    expect_begin_next();
    do_handshake(1, 1);
  endtask

  task automatic test_random_games();
    int n;
    int sz;
    for (int g = 0; g < 4; g++) begin
      load_seed((g == 0) ? 16'h0000 : 16'($urandom_range(1, 65535)));
      sz = $urandom_range(2, 8);
      gen_board(sz, $urandom_range(0, 15), 0, n);
      if (n != sz * sz) begin
        failures++;
        $display("FAIL random_count: got %0d writes, required %0d", n, sz * sz);
      end
      checks++;
      expect_begin_next();
      do_handshake($urandom_range(1, 4), $urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_small_board();
    test_handshake();
    test_large_board();
    test_changing_color();
    test_bad_cfg();
    test_reset_mid();
    test_random_games();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_generator.md
Name: board_generator

Overview:
- Produces a random SIZE x SIZE Flood-It starting board and writes it cell by cell into the initial-board store.
- Then drives the BEGIN_GAME / STARTED_GAME start handshake toward the game-logic block, which copies that store into its live board.
- Sits between the menu/config front end and the game logic. It is the writer of the initial board and the initiator of the game-start handshake.

Parameters:
- LFSR_W, 16, width of the pseudo-random generator.
- DEFAULT_SEED, 16'hACE1, seed substituted whenever a zero seed is loaded.
- MAX_SIZE, 26, largest legal board edge.

Ports:
- CLOCK  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- NEW_GAME  in  1  one-cycle request to generate a board and start a game.
- SEED  in  16  seed value.
- SEED_LOAD  in  1  loads SEED into the LFSR.
- SIZE  in  5  board edge; legal values are 2..26.
- COLOR_NUM  in  4  number of colours; legal values are 2..8.
- CELL_WE  out  1  write strobe to the initial-board store.
- CELL_ROW  out  5  row of the cell being written.
- CELL_COL  out  5  column of the cell being written.
- CELL_COLOR  out  3  colour of the cell being written.
- BEGIN_GAME  out  1  start request to game logic.
- STARTED_GAME  in  1  start acknowledge from game logic.
- CHANGING_COLOR  in  1  game logic busy flooding.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the handshake completes.
- BAD_CFG  out  1  sticky flag: last NEW_GAME had an illegal SIZE.

Behaviour:
- Reset values (async, RESET_N low):
  - State IDLE.
  - LFSR = DEFAULT_SEED.
  - All outputs 0, including BAD_CFG.
  - CELL_ROW/COL/COLOR = 0.
- LFSR:
  - 16-bit Galois, taps 16'hB400, shifts right.
  - Advances exactly once per cycle while in DRAW; it holds in all other states.
  - SEED_LOAD (any state) loads SEED, or DEFAULT_SEED if SEED == 0. SEED_LOAD takes priority over the advance in the same cycle.
  - Candidate colour is lfsr[2:0].
- Config latch:
  - On NEW_GAME in IDLE, latch SIZE into sz_q and COLOR_NUM into cn_q.
  - cn_q clamps to 2 if COLOR_NUM < 2, and to 8 if COLOR_NUM > 8.
  - If SIZE < 2 or SIZE > MAX_SIZE: set BAD_CFG, stay in IDLE, no writes.
  - A legal NEW_GAME clears BAD_CFG.
  - NEW_GAME outside IDLE is ignored.
- States:
  - IDLE: on a legal NEW_GAME, set row = col = 0, go to DRAW.
  - DRAW (rejection sampling):
    - If lfsr[2:0] < cn_q, accept. Next cycle CELL_WE = 1, with CELL_ROW = row, CELL_COL = col, CELL_COLOR = lfsr[2:0].
    - If rejected, CELL_WE = 0 and the draw retries on the next cycle.
    - Traversal is row-major: col increments first, wraps to 0 at sz_q-1, and row then increments.
    - After accepting cell (sz_q-1, sz_q-1), go to WAIT_IDLE.
    - CELL_WE is always a single-cycle pulse per accepted cell. Exactly sz_q*sz_q writes occur, and no cell is written twice.
  - WAIT_IDLE: hold while CHANGING_COLOR = 1 (game logic ignores BEGIN_GAME mid-flood). When it is 0, set BEGIN_GAME = 1 and go to HANDOFF.
  - HANDOFF: BEGIN_GAME held at 1 until STARTED_GAME = 1 is sampled. Then BEGIN_GAME = 0 on the next edge, go to RELEASE.
  - RELEASE: wait for STARTED_GAME = 0. Then pulse DONE for one cycle, go to IDLE.
- Outputs:
  - BUSY = (state != IDLE), decoded from the registered state.
  - BEGIN_GAME is registered and is never high outside HANDOFF.
- Reset mid-operation: returns to IDLE immediately with BEGIN_GAME = 0 and CELL_WE = 0. A partial board is left in the store and is not cleaned up.
- Latency: minimum sz_q*sz_q + 1 cycles from NEW_GAME to the first BEGIN_GAME. The handshake adds at least 2 cycles plus the responder's latency.

Decomposition:
- Shared package flood_pkg holds:
  - MAX_SIZE.
  - Colour width (3).
  - Coordinate width (5).
  - DEFAULT_SEED.
  - The state enum for this block.
- The LFSR is a natural sub-module, lfsr16 (ports: CLOCK, RESET_N, EN, LOAD, SEED, Q), reusable for other random features.

Test Plan:
1. Reset, SEED_LOAD with SEED = 16'h0001, SIZE = 2, COLOR_NUM = 8, NEW_GAME -> exactly 4 CELL_WE pulses in consecutive cycles, at (0,0),(0,1),(1,0),(1,1). Colours equal lfsr[2:0] of a reference Galois model. Then BEGIN_GAME = 1.
2. SIZE = 26, COLOR_NUM = 3, random seed -> 676 writes, every CELL_COLOR in 0..2, row-major order, no duplicate coordinates. Gaps appear only on rejected draws (lfsr[2:0] >= 3).
3. Responder model asserts STARTED_GAME 3 cycles after BEGIN_GAME and drops it 2 cycles after BEGIN_GAME falls -> BEGIN_GAME falls the cycle after STARTED_GAME is seen. DONE pulses once, BUSY = 0 afterward.
4. CHANGING_COLOR = 1 when generation finishes, held 10 cycles -> BEGIN_GAME stays 0 for all 10 cycles and rises the cycle after CHANGING_COLOR falls.
5. SIZE = 27 (and separately SIZE = 1) with NEW_GAME -> BAD_CFG = 1, no CELL_WE, BUSY = 0. A following legal NEW_GAME clears BAD_CFG.
6. RESET_N low during the 50th write of a SIZE = 10 game -> CELL_WE, BEGIN_GAME and BUSY go 0 immediately. LFSR returns to 16'hACE1. A new NEW_GAME restarts at (0,0).
